// File: rtl/pipe_rr_sched_if.sv
// Request/response bundle for the shared adder scheduler.
// The slave modport is the scheduler side; the master modport is the producer/consumer side.
interface pipe_rr_sched_if #(
  parameter int N = 4,
  parameter int W = 32
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N-1:0][W-1:0]  req_a;
  logic [N-1:0][W-1:0]  req_b;
  logic [N-1:0][W-1:0]  req_c;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [W-1:0]         rsp_data;
  logic [IDW-1:0]       rsp_id;
  logic                 busy;

  modport slave (
    input  req_valid, req_a, req_b, req_c, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_c, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/pipe_rr_sched.sv
// Round-robin front end sharing one two-stage adder (f1=a+b, f2=b+c, out=f1+f2) among N requesters.
// Results return tagged with the requester index, in acceptance order.
module pipe_rr_sched #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic            clk,
  input  logic            rst,
  pipe_rr_sched_if.slave  sched
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic           en;
  logic           found;
  logic           accept;
  logic [IDW-1:0] gnt;
  logic [N-1:0]   ready_w;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           v1_q, v1_d;
  logic [W-1:0]   f1_q, f1_d;
  logic [W-1:0]   f2_q, f2_d;
  logic [IDW-1:0] id1_q, id1_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;

  assign en     = !rsp_valid_q || sched.rsp_ready;
  assign accept = en && found;

  // Cyclic search starting just after the last granted requester.
  always_comb begin
    logic [IDW-1:0] idx;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDW'((int'(ptr_q) + k) % N);
      if (!found && sched.req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  always_comb begin
    ready_w = '0;
    if (accept) ready_w[gnt] = 1'b1;
  end

  always_comb begin
    ptr_d       = accept ? gnt : ptr_q;
    v1_d        = en ? accept : v1_q;
    f1_d        = accept ? sched.req_a[gnt] + sched.req_b[gnt] : f1_q;
    f2_d        = accept ? sched.req_b[gnt] + sched.req_c[gnt] : f2_q;
    id1_d       = accept ? gnt : id1_q;
    rsp_valid_d = en ? v1_q : rsp_valid_q;
    rsp_data_d  = en ? f1_q + f2_q : rsp_data_q;
    rsp_id_d    = en ? id1_q : rsp_id_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= IDW'(N - 1);
      v1_q        <= 1'b0;
      f1_q        <= '0;
      f2_q        <= '0;
      id1_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      v1_q        <= v1_d;
      f1_q        <= f1_d;
      f2_q        <= f2_d;
      id1_q       <= id1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign sched.req_ready = ready_w;
  assign sched.rsp_valid = rsp_valid_q;
  assign sched.rsp_data  = rsp_data_q;
  assign sched.rsp_id    = rsp_id_q;
  assign sched.busy      = v1_q || rsp_valid_q;
endmodule

// File: tb/tb_pipe_rr_sched.sv
// Directed bench for pipe_rr_sched with N=4, W=32.
// Every task starts and ends 1 time unit after a rising clock edge.
module tb_pipe_rr_sched;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  pipe_rr_sched_if #(.N(4), .W(32)) bus ();

  pipe_rr_sched #(.N(4), .W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .sched (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i] = '0;
      bus.req_b[i] = '0;
      bus.req_c[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (bus.rsp_data !== 32'h0 || bus.rsp_id !== 2'd0) begin
      fails++;
      $display("FAIL reset_data: data=%0h id=%0d want 0/0", bus.rsp_data, bus.rsp_id);
    end
    for (int c = 0; c < 10; c++) begin
      #1;
      tests++;
      if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle c%0d: ready=%b rsp_valid=%b busy=%b want 0000/0/0",
                 c, bus.req_ready, bus.rsp_valid, bus.busy);
      end
      tick();
    end
  endtask

  task automatic test_single();
    bus.req_valid = 4'b0001;
    bus.req_a[0] = 32'd1; bus.req_b[0] = 32'd2; bus.req_c[0] = 32'd3;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL single_grant: ready=%b want 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL single_t1: rsp_valid=%b busy=%b want 0/1", bus.rsp_valid, bus.busy);
    end
    tick();
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd8 || bus.rsp_id !== 2'd0) begin
      fails++;
      $display("FAIL single_rsp: valid=%b data=%0d id=%0d want 1/8/0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    tick();
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL single_drain: rsp_valid=%b busy=%b want 0/0", bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_data [4];
    exp_data[0] = 32'd101; exp_data[1] = 32'd134;
    exp_data[2] = 32'd167; exp_data[3] = 32'd200;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i] = 32'(i + 1);
      bus.req_b[i] = 32'(i * 16);
      bus.req_c[i] = 32'd100;
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc >= 2) begin
        tests++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'((cyc - 2) % 4) ||
            bus.rsp_data !== exp_data[(cyc - 2) % 4]) begin
          fails++;
          $display("FAIL rr_rsp c%0d: valid=%b id=%0d data=%0d want 1/%0d/%0d", cyc,
                   bus.rsp_valid, bus.rsp_id, bus.rsp_data, (cyc - 2) % 4, exp_data[(cyc - 2) % 4]);
        end
      end
      bus.req_valid = (cyc < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (cyc < 8) begin
        tests++;
        if (bus.req_ready !== 4'(1 << (cyc % 4))) begin
          fails++;
          $display("FAIL rr_grant c%0d: ready=%b want %b", cyc, bus.req_ready, 4'(1 << (cyc % 4)));
        end
      end
      tick();
    end
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL rr_end: rsp_valid=%b busy=%b want 0/0", bus.rsp_valid, bus.busy);
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    bus.req_valid = 4'b0100;
    bus.req_a[2] = 32'hFFFF_FFFF; bus.req_b[2] = 32'h1; bus.req_c[2] = 32'h0;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL wrap_grant0: ready=%b want 0100", bus.req_ready);
    end
    tick();
    bus.req_a[2] = 32'h0; bus.req_b[2] = 32'h8000_0000; bus.req_c[2] = 32'h0;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL wrap_grant1: ready=%b want 0100", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h1 || bus.rsp_id !== 2'd2) begin
      fails++;
      $display("FAIL wrap_rsp0: valid=%b data=%0h id=%0d want 1/1/2",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    tick();
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0 || bus.rsp_id !== 2'd2) begin
      fails++;
      $display("FAIL wrap_rsp1: valid=%b data=%0h id=%0d want 1/0/2",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    bus.req_valid = 4'b0010;
    bus.req_a[1] = 32'd5; bus.req_b[1] = 32'd5; bus.req_c[1] = 32'd5;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL b2b_grant0: ready=%b want 0010", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b1000;
    bus.req_a[3] = 32'd1; bus.req_b[3] = 32'd1; bus.req_c[3] = 32'd1;
    #1;
    tests++;
    if (bus.req_ready !== 4'b1000) begin
      fails++;
      $display("FAIL b2b_grant1: ready=%b want 1000", bus.req_ready);
    end
    tick();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++;
      if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd20 ||
          bus.rsp_id !== 2'd1 || bus.busy !== 1'b1) begin
        fails++;
        $display("FAIL b2b_stall c%0d: ready=%b valid=%b data=%0d id=%0d busy=%b want 0000/1/20/1/1",
                 c, bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.busy);
      end
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd20 || bus.rsp_id !== 2'd1) begin
      fails++;
      $display("FAIL b2b_drain0: valid=%b data=%0d id=%0d want 1/20/1",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    tick();
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd4 || bus.rsp_id !== 2'd3) begin
      fails++;
      $display("FAIL b2b_drain1: valid=%b data=%0d id=%0d want 1/4/3",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    tick();
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_empty: rsp_valid=%b busy=%b want 0/0", bus.rsp_valid, bus.busy);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    bus.req_a[0] = 32'd9; bus.req_b[0] = 32'd9; bus.req_c[0] = 32'd9;
    bus.req_a[1] = 32'd2; bus.req_b[1] = 32'd3; bus.req_c[1] = 32'd4;
    bus.req_a[2] = 32'd6; bus.req_b[2] = 32'd6; bus.req_c[2] = 32'd6;
    bus.req_valid = 4'b0011;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL rstmid_grant0: ready=%b want 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0010;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL rstmid_grant1: ready=%b want 0010", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_inflight: rsp_valid=%b busy=%b want 1/1", bus.rsp_valid, bus.busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tests++;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
        fails++;
        $display("FAIL rstmid_flush c%0d: rsp_valid=%b busy=%b want 0/0", c, bus.rsp_valid, bus.busy);
      end
      tick();
    end
    bus.req_valid = 4'b0110;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL rstmid_first_grant: ready=%b want 0010", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    tick();
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd12 || bus.rsp_id !== 2'd1) begin
      fails++;
      $display("FAIL rstmid_rsp: valid=%b data=%0d id=%0d want 1/12/1",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    tick();
    clear_inputs();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
